// File: rtl/wb_b3_slv_pkg.sv
// wb_b3_slv_pkg: shared types and helpers for the Wishbone B3 memory slave.
// Holds FSM/response encodings and the data-parity function.
package wb_b3_slv_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;
  typedef enum logic [1:0] {RSP_ACK, RSP_ERR, RSP_RTY} rsp_e;

  localparam int DAT_W_DEF = 64;
  localparam int SEL_W = DAT_W_DEF / 8;
  localparam int PAR_W = 1024;

  // Callers zero-extend with PAR_W'(x); padding does not change XOR.
  function automatic logic parity(input logic [PAR_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/wb_b3_slv_ram.sv
// wb_b3_slv_ram: DEPTH x DAT_W storage, per-byte write enables,
// combinational read port.
module wb_b3_slv_ram
  import wb_b3_slv_pkg::*;
#(
  parameter int DAT_W = 64,
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic               clk,
  input  logic [DAT_W/8-1:0] be,
  input  logic [AW-1:0]      addr,
  input  logic [DAT_W-1:0]   wdata,
  output logic [DAT_W-1:0]   rdata
);

  logic [DAT_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int b = 0; b < DAT_W / 8; b++) begin
      if (be[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/wb_b3_slave_mem.sv
// wb_b3_slave_mem: Wishbone B3 classic slave memory with wait/err/rty.
// Define WB_SLV_PARITY_CHK_EN to reject writes whose tgd_i != ^dat_i.
module wb_b3_slave_mem
  import wb_b3_slv_pkg::*;
#(
  parameter int DAT_W      = 64,
  parameter int ADR_W      = 8,
  parameter int DEPTH      = 256,
  parameter int WAIT_CYC   = 0,
  parameter int RTY_PERIOD = 0
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [ADR_W-1:0]   adr_i,
  input  logic [DAT_W-1:0]   dat_i,
  output logic [DAT_W-1:0]   dat_o,
  input  logic [DAT_W/8-1:0] sel_i,
  input  logic               we_i,
  input  logic               cyc_i,
  input  logic               stb_i,
  input  logic               lock_i,
  input  logic               tgd_i,
  output logic               tgd_o,
  output logic               ack_o,
  output logic               err_o,
  output logic               rty_o
);

  localparam int SW = DAT_W / 8;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_e           state;
  logic [3:0]       wcnt;
  logic [15:0]      rcnt;
  logic [15:0]      rcnt_nxt;
  logic [ADR_W-1:0] adr_q;
  logic [ADR_W-1:0] adr_c;
  logic             we_q;
  logic             we_c;
  logic [SW-1:0]    sel_q;
  logic [SW-1:0]    sel_c;
  logic [SW-1:0]    be;
  logic [DAT_W-1:0] dat_q;
  logic [DAT_W-1:0] dat_c;
  logic [DAT_W-1:0] rd_data;
  logic             req;
  logic             enter;
  logic             hit;
  logic             par_bad;
  rsp_e             rsp;

  assign req = cyc_i & stb_i;

  // Zero-wait requests resolve straight from the bus, others from latches.
  always_comb begin
    adr_c = (state == IDLE) ? adr_i : adr_q;
    we_c  = (state == IDLE) ? we_i  : we_q;
    sel_c = (state == IDLE) ? sel_i : sel_q;
    dat_c = (state == IDLE) ? dat_i : dat_q;
    enter = 1'b0;
    if (state == IDLE) enter = req && (WAIT_CYC == 0);
    else if (state == WAIT) enter = cyc_i && (wcnt == 4'd0);
  end

`ifdef WB_SLV_PARITY_CHK_EN
  logic tgd_q;
  logic tgd_c;
  assign tgd_c   = (state == IDLE) ? tgd_i : tgd_q;
  assign par_bad = we_c && (tgd_c != parity(PAR_W'(dat_c)));
`else
  logic unused_tgd;
  assign unused_tgd = tgd_i;
  assign par_bad    = 1'b0;
`endif

  // Saturates at RTY_PERIOD so an err at the hit point defers the retry.
  assign rcnt_nxt = (32'(rcnt) >= RTY_PERIOD) ? rcnt : rcnt + 16'd1;
  assign hit = (RTY_PERIOD != 0) && !lock_i &&
               (32'(rcnt_nxt) >= RTY_PERIOD);

  always_comb begin
    if (32'(adr_c) >= DEPTH) rsp = RSP_ERR;
    else if (par_bad)        rsp = RSP_ERR;
    else if (hit)            rsp = RSP_RTY;
    else                     rsp = RSP_ACK;
  end

  assign be = (enter && rsp == RSP_ACK && we_c) ? sel_c : '0;

  wb_b3_slv_ram #(
    .DAT_W (DAT_W),
    .DEPTH (DEPTH),
    .AW    (IW)
  ) u_ram (
    .clk   (clk),
    .be    (be),
    .addr  (adr_c[IW-1:0]),
    .wdata (dat_c),
    .rdata (rd_data)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      wcnt  <= '0;
      rcnt  <= '0;
      adr_q <= '0;
      we_q  <= 1'b0;
      sel_q <= '0;
      dat_q <= '0;
`ifdef WB_SLV_PARITY_CHK_EN
      tgd_q <= 1'b0;
`endif
      ack_o <= 1'b0;
      err_o <= 1'b0;
      rty_o <= 1'b0;
      dat_o <= '0;
      tgd_o <= 1'b0;
    end else begin
      ack_o <= 1'b0;
      err_o <= 1'b0;
      rty_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req) begin
            adr_q <= adr_i;
            we_q  <= we_i;
            sel_q <= sel_i;
            dat_q <= dat_i;
`ifdef WB_SLV_PARITY_CHK_EN
            tgd_q <= tgd_i;
`endif
            if (WAIT_CYC == 0) begin
              state <= RESP;
            end else begin
              state <= WAIT;
              wcnt  <= 4'(WAIT_CYC - 1);
            end
          end
        end
        WAIT: begin
          if (!cyc_i) begin
            state <= IDLE;
            wcnt  <= '0;
          end else if (wcnt == 4'd0) begin
            state <= RESP;
          end else begin
            wcnt <= wcnt - 4'd1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
      if (enter) begin
        ack_o <= (rsp == RSP_ACK);
        err_o <= (rsp == RSP_ERR);
        rty_o <= (rsp == RSP_RTY);
        if (!lock_i) rcnt <= (rsp == RSP_RTY) ? '0 : rcnt_nxt;
        if (rsp != RSP_ACK) begin
          dat_o <= '0;
          tgd_o <= 1'b0;
        end else if (!we_c) begin
          dat_o <= rd_data;
          tgd_o <= parity(PAR_W'(rd_data));
        end
      end
    end
  end

endmodule
